// File: rtl/imem_loader.sv
// imem_loader: program-loading initiator for a 1-write-port, combinational-read
// 32-bit word memory. Streams words over valid/ready into consecutive word
// addresses from BASE_ADDR, holds the CPU until the image is committed, then
// reports done or error.
// Optional readback checksum verification: define IMEM_LOADER_VERIFY_EN.
//
// Handshake: a word moves on a posedge where in_valid && in_ready are both
// high. The source keeps in_data stable while in_valid is high and in_ready
// is low; in_ready never depends on in_valid.
module imem_loader #(
    parameter int DEPTH     = 1024,
    parameter int BASE_ADDR = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [10:0] load_count,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    output logic        mem_write_enable,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_data_in,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_data_out,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [10:0] words_written,
    output logic        cpu_hold
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_FLUSH  = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd4;
    localparam logic [2:0] ST_ERROR  = 3'd5;
`ifdef IMEM_LOADER_VERIFY_EN
    localparam logic [2:0] ST_VERIFY = 3'd3;
    localparam logic [2:0] FLUSH_NEXT = ST_VERIFY;
`else
    localparam logic [2:0] FLUSH_NEXT = ST_DONE;
`endif

    localparam logic [31:0] BASE_W  = 32'(BASE_ADDR);
    localparam logic [31:0] DEPTH_W = 32'(DEPTH);

    logic [2:0]  state;
    logic [10:0] count_q;      // load_count captured on the accepted start
    logic        start_ok;
    logic        range_bad;
    logic [31:0] end_addr;
    logic        xfer;
    logic        last_xfer;
    logic        in_verify;
    logic        verify_last;
    logic        verify_pass;

    assign start_ok  = start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign end_addr  = BASE_W + {21'd0, load_count};
    assign range_bad = end_addr > DEPTH_W;

    assign in_ready  = (state == ST_LOAD) && (words_written < count_q);
    assign xfer      = in_valid && in_ready;
    assign last_xfer = xfer && (({21'd0, words_written} + 32'd1) == {21'd0, count_q});

    assign busy      = (state == ST_LOAD) || (state == ST_FLUSH) || in_verify;
    assign done      = (state == ST_DONE);
    assign error     = (state == ST_ERROR);
    assign cpu_hold  = (state != ST_DONE);

    // Main control FSM and the accepted-word counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            count_q       <= '0;
            words_written <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start_ok) begin
                        count_q       <= load_count;
                        words_written <= '0;
                        if (range_bad)
                            state <= ST_ERROR;
                        else if (load_count == 11'd0)
                            state <= ST_DONE;
                        else
                            state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (xfer) begin
                        words_written <= words_written + 11'd1;
                        if (last_xfer)
                            state <= ST_FLUSH;
                    end
                end
                // One cycle for the final registered write to reach memory
                ST_FLUSH: state <= FLUSH_NEXT;
`ifdef IMEM_LOADER_VERIFY_EN
                ST_VERIFY: begin
                    if (verify_last)
                        state <= verify_pass ? ST_DONE : ST_ERROR;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Registered memory write port; address/data hold when no transfer
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_write_enable  <= 1'b0;
            mem_write_address <= '0;
            mem_data_in       <= '0;
        end else begin
            mem_write_enable <= xfer;
            if (xfer) begin
                mem_write_address <= BASE_W + {21'd0, words_written};
                mem_data_in       <= in_data;
            end
        end
    end

`ifdef IMEM_LOADER_VERIFY_EN
    logic [10:0] vidx;
    logic [31:0] load_sum;
    logic [31:0] read_sum;

    assign in_verify        = (state == ST_VERIFY);
    assign verify_last      = in_verify && (vidx == count_q - 11'd1);
    // The last word read is folded in combinationally so the decision lands on its edge
    assign verify_pass      = (load_sum == read_sum + mem_data_out);
    assign mem_read_address = in_verify ? (BASE_W + {21'd0, vidx}) : 32'd0;

    // Checksums over the streamed words and the memory readback
    always_ff @(posedge clk) begin
        if (rst) begin
            vidx     <= '0;
            load_sum <= '0;
            read_sum <= '0;
        end else if (start_ok) begin
            vidx     <= '0;
            load_sum <= '0;
            read_sum <= '0;
        end else begin
            if (xfer)
                load_sum <= load_sum + in_data;
            if (in_verify) begin
                read_sum <= read_sum + mem_data_out;
                vidx     <= vidx + 11'd1;
            end
        end
    end
`else
    logic unused_data_out;

    assign in_verify        = 1'b0;
    assign verify_last      = 1'b0;
    assign verify_pass      = 1'b0;
    assign mem_read_address = 32'd0;
    assign unused_data_out  = ^{mem_data_out, verify_last, verify_pass};
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed bench for imem_loader. Two instances share the
// stream inputs: u_dut0 loads at BASE_ADDR 0, u_dut1 at BASE_ADDR 1020 for
// the top-of-memory boundary. Each drives its own behavioural memory.
// Edge numbering: edge 0 is the posedge right before start is raised, so
// start is accepted at edge 1 and done rises at edge N+2 (2N+2 with
// IMEM_LOADER_VERIFY_EN).
module tb_imem_loader;

`ifdef IMEM_LOADER_VERIFY_EN
    localparam int VERIFY_ON = 1;
`else
    localparam int VERIFY_ON = 0;
`endif

    // Clock and reset
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #5 clk = ~clk;

    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [10:0] load_count = '0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        corrupt = 1'b0;

    logic        in_ready0, mem_write_enable0, busy0, done0, error0, cpu_hold0;
    logic [31:0] mem_write_address0, mem_data_in0, mem_read_address0, mem_data_out0;
    logic [10:0] words_written0;
    logic        in_ready1, mem_write_enable1, busy1, done1, error1, cpu_hold1;
    logic [31:0] mem_write_address1, mem_data_in1, mem_read_address1, mem_data_out1;
    logic [10:0] words_written1;

    logic [31:0] mem0 [0:1023];
    logic [31:0] mem1 [0:1023];
    logic [31:0] prog [0:3] = '{32'h2008_0020, 32'h2009_0001, 32'hAD28_0010, 32'h8D2A_0010};

    int nchecks = 0;
    int nfail   = 0;

    imem_loader #(.DEPTH(1024), .BASE_ADDR(0)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .load_count(load_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready0),
        .mem_write_enable(mem_write_enable0), .mem_write_address(mem_write_address0),
        .mem_data_in(mem_data_in0), .mem_read_address(mem_read_address0),
        .mem_data_out(mem_data_out0), .busy(busy0), .done(done0), .error(error0),
        .words_written(words_written0), .cpu_hold(cpu_hold0)
    );

    imem_loader #(.DEPTH(1024), .BASE_ADDR(1020)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .load_count(load_count),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready1),
        .mem_write_enable(mem_write_enable1), .mem_write_address(mem_write_address1),
        .mem_data_in(mem_data_in1), .mem_read_address(mem_read_address1),
        .mem_data_out(mem_data_out1), .busy(busy1), .done(done1), .error(error1),
        .words_written(words_written1), .cpu_hold(cpu_hold1)
    );

    // Behavioural memories: one-cycle write, combinational read.
    // corrupt flips a bit of word 1 on the read path only.
    always @(posedge clk) begin
        if (mem_write_enable0) mem0[mem_write_address0[9:0]] <= mem_data_in0;
        if (mem_write_enable1) mem1[mem_write_address1[9:0]] <= mem_data_in1;
    end
    assign mem_data_out0 = mem0[mem_read_address0[9:0]]
                         ^ ((corrupt && mem_read_address0 == 32'd1) ? 32'h0000_0100 : 32'd0);
    assign mem_data_out1 = mem1[mem_read_address1[9:0]];

    function automatic int exp_end_edge(input int n, input int gap);
        if (n == 0) return 1;
        return ((VERIFY_ON != 0) ? (2 * n + 2) : (n + 2)) + gap;
    endfunction

    // Driver: runs one load on DUT sel with words prog[i]^key, an optional
    // in_valid gap after the second word, until done/error or a 200-edge budget.
    task automatic drive_load(input bit sel, input int n, input int gap_len,
                              input logic [31:0] key,
                              output int we_cycles, output int gap_writes,
                              output int gap_ww_bad, output int end_edge,
                              output bit ended_done, output bit hold_ok);
        int  edge_n;
        int  wi;
        int  gap_left;
        bit  rdy;
        @(posedge clk); #1;
        if (sel) start1 = 1'b1; else start0 = 1'b1;
        load_count = n[10:0];
        in_valid   = (n > 0);
        in_data    = prog[0] ^ key;
        edge_n = 0; wi = 0; gap_left = 0;
        we_cycles = 0; gap_writes = 0; gap_ww_bad = 0;
        end_edge = -1; ended_done = 1'b0; hold_ok = 1'b1;
        while (end_edge < 0 && edge_n < 200) begin
            rdy = sel ? in_ready1 : in_ready0;
            @(posedge clk); edge_n++; #1;
            start0 = 1'b0; start1 = 1'b0;
            if (sel ? mem_write_enable1 : mem_write_enable0) we_cycles++;
            if (rdy && in_valid) begin
                wi++;
                in_data = (wi < 4) ? (prog[wi] ^ key) : 32'd0;
                if (wi == n) in_valid = 1'b0;
                else if (wi == 2 && gap_len > 0) begin
                    in_valid = 1'b0;
                    gap_left = gap_len;
                end
            end else if (gap_left > 0) begin
                if (sel ? mem_write_enable1 : mem_write_enable0) gap_writes++;
                if ((sel ? words_written1 : words_written0) != 11'd2) gap_ww_bad++;
                gap_left--;
                if (gap_left == 0) in_valid = 1'b1;
            end
            if ((sel ? cpu_hold1 : cpu_hold0) !== ~(sel ? done1 : done0)) hold_ok = 1'b0;
            if ((sel ? done1 : done0) || (sel ? error1 : error0)) begin
                end_edge   = edge_n;
                ended_done = sel ? done1 : done0;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if (cpu_hold0 !== 1'b1) begin nfail++; $display("FAIL reset_cpu_hold: got %b want 1", cpu_hold0); end
        nchecks++;
        if ({done0, error0, busy0, in_ready0, mem_write_enable0} !== 5'b0) begin
            nfail++; $display("FAIL reset_flags: got %b want 00000", {done0, error0, busy0, in_ready0, mem_write_enable0});
        end
        nchecks++;
        if (words_written0 !== 11'd0) begin nfail++; $display("FAIL reset_words_written: got %0d want 0", words_written0); end
        nchecks++;
        if ({mem_write_address0, mem_data_in0, mem_read_address0} !== 96'd0) begin
            nfail++; $display("FAIL reset_addr_data: got %h %h %h want zeros", mem_write_address0, mem_data_in0, mem_read_address0);
        end
        nchecks++;
        if (cpu_hold1 !== 1'b1 || done1 !== 1'b0) begin nfail++; $display("FAIL reset_dut1: hold %b done %b want 1 0", cpu_hold1, done1); end
        nchecks++;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_basic_load();
        int we_c, gw, gb, ee; bit ok_done, hold_ok;
        drive_load(1'b0, 4, 0, 32'd0, we_c, gw, gb, ee, ok_done, hold_ok);
        if (we_c != 4) begin nfail++; $display("FAIL basic_we_cycles: got %0d want 4", we_c); end
        nchecks++;
        if (ee != exp_end_edge(4, 0) || !ok_done) begin
            nfail++; $display("FAIL basic_done_edge: got edge %0d done %b want edge %0d done 1", ee, ok_done, exp_end_edge(4, 0));
        end
        nchecks++;
        if (!hold_ok || cpu_hold0 !== 1'b0) begin nfail++; $display("FAIL basic_cpu_hold: tracked %b final %b want 1 0", hold_ok, cpu_hold0); end
        nchecks++;
        if (words_written0 !== 11'd4) begin nfail++; $display("FAIL basic_words_written: got %0d want 4", words_written0); end
        nchecks++;
        for (int i = 0; i < 4; i++) begin
            if (mem0[i] !== prog[i]) begin nfail++; $display("FAIL basic_mem[%0d]: got %h want %h", i, mem0[i], prog[i]); end
            nchecks++;
        end
    endtask

    task automatic test_back_pressure();
        int we_c, gw, gb, ee; bit ok_done, hold_ok;
        drive_load(1'b0, 4, 3, 32'd0, we_c, gw, gb, ee, ok_done, hold_ok);
        if (gw != 0) begin nfail++; $display("FAIL bp_gap_writes: got %0d want 0", gw); end
        nchecks++;
        if (gb != 0) begin nfail++; $display("FAIL bp_gap_words_written: %0d gap cycles not at 2", gb); end
        nchecks++;
        if (we_c != 4 || ee != exp_end_edge(4, 3) || !ok_done) begin
            nfail++; $display("FAIL bp_timing: we %0d edge %0d done %b want 4 %0d 1", we_c, ee, ok_done, exp_end_edge(4, 3));
        end
        nchecks++;
        for (int i = 0; i < 4; i++) begin
            if (mem0[i] !== prog[i]) begin nfail++; $display("FAIL bp_mem[%0d]: got %h want %h", i, mem0[i], prog[i]); end
            nchecks++;
        end
    endtask

    task automatic test_zero_count();
        int we_c, gw, gb, ee; bit ok_done, hold_ok;
        drive_load(1'b0, 0, 0, 32'd0, we_c, gw, gb, ee, ok_done, hold_ok);
        if (ee != 1 || !ok_done || we_c != 0) begin
            nfail++; $display("FAIL zero_count: edge %0d done %b writes %0d want 1 1 0", ee, ok_done, we_c);
        end
        nchecks++;
    endtask

    task automatic test_overflow();
        int we_c, gw, gb, ee; bit ok_done, hold_ok;
        drive_load(1'b1, 5, 0, 32'd0, we_c, gw, gb, ee, ok_done, hold_ok);
        if (ee != 1 || ok_done || error1 !== 1'b1 || cpu_hold1 !== 1'b1) begin
            nfail++; $display("FAIL overflow_error: edge %0d done %b error %b hold %b want 1 0 1 1", ee, ok_done, error1, cpu_hold1);
        end
        nchecks++;
        repeat (3) @(posedge clk);
        #1;
        if (we_c != 0 || mem_write_enable1 !== 1'b0 || in_ready1 !== 1'b0) begin
            nfail++; $display("FAIL overflow_no_write: writes %0d we %b ready %b want 0 0 0", we_c, mem_write_enable1, in_ready1);
        end
        nchecks++;
    endtask

    task automatic test_top_of_memory();
        int we_c, gw, gb, ee; bit ok_done, hold_ok;
        drive_load(1'b1, 4, 0, 32'd0, we_c, gw, gb, ee, ok_done, hold_ok);
        if (we_c != 4 || ee != exp_end_edge(4, 0) || !ok_done) begin
            nfail++; $display("FAIL top_timing: we %0d edge %0d done %b want 4 %0d 1", we_c, ee, ok_done, exp_end_edge(4, 0));
        end
        nchecks++;
        for (int i = 0; i < 4; i++) begin
            if (mem1[1020 + i] !== prog[i]) begin nfail++; $display("FAIL top_mem[%0d]: got %h want %h", 1020 + i, mem1[1020 + i], prog[i]); end
            nchecks++;
        end
    endtask

    task automatic test_reset_mid_load();
        int we_c, gw, gb, ee; bit ok_done, hold_ok;
        int late_writes;
        logic [31:0] ka = 32'hFFFF_0000;
        logic [31:0] kb = 32'h0F0F_0F0F;
        @(posedge clk); #1;                      // edge 0
        start0 = 1'b1; load_count = 11'd4; in_valid = 1'b1; in_data = prog[0] ^ ka;
        @(posedge clk); #1; start0 = 1'b0;       // edge 1: start accepted
        @(posedge clk); #1; in_data = prog[1] ^ ka;   // edge 2: word 0
        @(posedge clk); #1;                      // edge 3: word 1
        if (words_written0 !== 11'd2) begin nfail++; $display("FAIL midrst_before: words_written %0d want 2", words_written0); end
        nchecks++;
        in_data = prog[2] ^ ka;
        rst = 1'b1;
        @(posedge clk); #1;                      // edge 4: reset
        rst = 1'b0;
        if (busy0 !== 1'b0 || mem_write_enable0 !== 1'b0 || cpu_hold0 !== 1'b1 || in_ready0 !== 1'b0 || words_written0 !== 11'd0) begin
            nfail++; $display("FAIL midrst_idle: busy %b we %b hold %b ready %b ww %0d want 0 0 1 0 0",
                              busy0, mem_write_enable0, cpu_hold0, in_ready0, words_written0);
        end
        nchecks++;
        late_writes = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (mem_write_enable0) late_writes++;
        end
        in_valid = 1'b0;
        if (late_writes != 0) begin nfail++; $display("FAIL midrst_no_writes: got %0d want 0", late_writes); end
        nchecks++;
        if (mem0[1] !== (prog[1] ^ ka) || mem0[2] !== prog[2]) begin
            nfail++; $display("FAIL midrst_mem: [1]=%h [2]=%h want %h %h", mem0[1], mem0[2], prog[1] ^ ka, prog[2]);
        end
        nchecks++;
        drive_load(1'b0, 4, 0, kb, we_c, gw, gb, ee, ok_done, hold_ok);
        if (we_c != 4 || ee != exp_end_edge(4, 0) || !ok_done) begin
            nfail++; $display("FAIL midrst_reload: we %0d edge %0d done %b want 4 %0d 1", we_c, ee, ok_done, exp_end_edge(4, 0));
        end
        nchecks++;
        for (int i = 0; i < 4; i++) begin
            if (mem0[i] !== (prog[i] ^ kb)) begin nfail++; $display("FAIL midrst_mem[%0d]: got %h want %h", i, mem0[i], prog[i] ^ kb); end
            nchecks++;
        end
    endtask

`ifdef IMEM_LOADER_VERIFY_EN
    task automatic test_verify();
        int we_c, gw, gb, ee; bit ok_done, hold_ok;
        corrupt = 1'b1;
        drive_load(1'b0, 4, 0, 32'd0, we_c, gw, gb, ee, ok_done, hold_ok);
        corrupt = 1'b0;
        if (ee != 10 || ok_done || error0 !== 1'b1 || cpu_hold0 !== 1'b1) begin
            nfail++; $display("FAIL verify_corrupt: edge %0d done %b error %b hold %b want 10 0 1 1", ee, ok_done, error0, cpu_hold0);
        end
        nchecks++;
        drive_load(1'b0, 4, 0, 32'd0, we_c, gw, gb, ee, ok_done, hold_ok);
        if (ee != 10 || !ok_done || error0 !== 1'b0) begin
            nfail++; $display("FAIL verify_clean: edge %0d done %b error %b want 10 1 0", ee, ok_done, error0);
        end
        nchecks++;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_load();
        test_back_pressure();
        test_zero_count();
        test_overflow();
        test_top_of_memory();
        test_reset_mid_load();
`ifdef IMEM_LOADER_VERIFY_EN
        test_verify();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
        $finish;
    end

endmodule
